gravity_drop_engine: RTL and testbench
======================================

Name: gravity_drop_engine

Overview:
Parametrised, clocked token-drop engine for the Connect-style game board. It accepts one column request per handshake and scans that column upward from the bottom row, one row per clock. It places the current player's token in the first empty cell, or reports the column as full. It owns the board occupancy and ownership registers and the turn bit; the game FSM and win checker consume these outputs.

Parameters:
COLS, 4, number of board columns (2..16)
ROWS, 4, number of board rows (2..16)
COL_W, 2, width of column select; must satisfy 2**COL_W >= COLS
ROW_W, 2, width of row index; must satisfy 2**ROW_W >= ROWS

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
clear  in  1  synchronous new-game clear
drop_valid  in  1  column request valid
drop_col  in  COL_W  requested column, 0 = leftmost
drop_ready  out  1  engine idle and able to accept a request
occupied  out  ROWS*COLS  1 = cell holds a token; cell index = row*COLS + col, row 0 = bottom
owner  out  ROWS*COLS  token owner: 0 = player1, 1 = player2; 0 when the cell is empty
player  out  1  player whose token the next accepted drop places
done  out  1  one-cycle pulse: token placed
done_row  out  ROW_W  row of the last placed token; held until the next done
invalid  out  1  one-cycle pulse: request rejected (column full or out of range)
board_full  out  1  all cells occupied (combinational AND of occupied)

Behaviour:
- Reset (async) and clear (sync): occupied=0, owner=0, player=0, done=0, invalid=0, done_row=0, state=IDLE, drop_ready=1.
- Priority: reset > clear > normal operation. A clear during SCAN aborts the drop; no done or invalid pulse is produced.
- FSM states: IDLE, SCAN.
- IDLE: drop_ready=1. When drop_valid=1 and drop_ready=1 (accept edge), latch drop_col into col_q and the current player into ply_q, set row_q=0, and go to SCAN. drop_valid with drop_ready=0 is ignored; it is not queued.
- SCAN: drop_ready=0. Each cycle, exactly one of the following applies:
  - col_q >= COLS: assert invalid; return to IDLE; board and player unchanged.
  - Cell(row_q, col_q) is empty: set occupied=1 and owner=ply_q for that cell; assert done; done_row=row_q; player toggles; return to IDLE.
  - Cell is occupied and row_q == ROWS-1: assert invalid; return to IDLE; player unchanged (the same player retries).
  - Otherwise: row_q increments by 1.
- Latency: a drop that lands in row r produces done on the (r+1)th rising edge after the accept edge. A full column produces invalid on the ROWS-th edge. An out-of-range column produces invalid on the 1st edge.
- done and invalid are never asserted in the same cycle, and each pulse lasts exactly one cycle.
- Board and player registers change only on a done edge, clear, or reset.
- With board_full=1, requests are still accepted and always end in invalid.
- The engine returns to IDLE before it can accept again, so the minimum spacing between accepts is 2 cycles.

Test Plan:
- Reset, then drop col 1 -> done 1 cycle after accept, done_row=0, occupied[1]=1, owner[1]=0, player=1.
- Four successive drops into col 2 (4x4 board) -> done_row 0,1,2,3 with latencies 1,2,3,4; owner[2,6,10,14]=0,1,0,1; player=0 afterwards.
- Fifth drop into col 2 -> invalid after 4 cycles, no done, occupied unchanged, player unchanged.
- COLS=3, COL_W=2, drop_col=3 -> invalid 1 cycle after accept, board unchanged.
- Assert clear 2 cycles into a scan up col 0 over 3 stacked tokens -> no done or invalid; occupied=0, player=0, drop_ready=1 the next cycle.
- Fill all 16 cells of the 4x4 board -> board_full=1 after the last done; the next request yields invalid. Asserting async reset mid-SCAN clears all outputs immediately.

Source files
------------

// File: rtl/gravity_drop_engine.sv
// gravity_drop_engine
// Token-drop engine for a Connect-style board. It accepts one column per
// handshake and scans that column upward from row 0, one row per clock. It
// drops the current player's token into the first empty cell, or rejects the
// request if the column is full or out of range. The engine owns the board
// occupancy/ownership registers and the turn bit.
//
// Handshake: a request is accepted on a rising edge where drop_valid and
// drop_ready are both 1. drop_ready is high only in IDLE. A drop_valid
// presented while drop_ready is low is ignored, not queued. Every accepted
// request ends in exactly one one-cycle pulse, either done or invalid, unless
// clear or reset aborts it first.

module gravity_drop_engine #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int COL_W = 2,
    parameter int ROW_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 drop_valid,
    input  logic [COL_W-1:0]     drop_col,
    output logic                 drop_ready,
    output logic [ROWS*COLS-1:0] occupied,
    output logic [ROWS*COLS-1:0] owner,
    output logic                 player,
    output logic                 done,
    output logic [ROW_W-1:0]     done_row,
    output logic                 invalid,
    output logic                 board_full,
    output logic [0:0]           state_dbg
);

    localparam int CELLS = ROWS * COLS;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             ply_q;

    int               cell_sel;
    logic [CELLS-1:0] cell_mask;
    logic             col_ok;
    logic             cell_busy;
    logic             at_top;

    // Locate the cell under the scan pointer and classify it.
    always_comb begin
        cell_sel  = int'(row_q) * COLS + int'(col_q);
        cell_mask = {{(CELLS-1){1'b0}}, 1'b1} << cell_sel;
        col_ok    = int'(col_q) < COLS;
        cell_busy = |(occupied & cell_mask);
        at_top    = int'(row_q) == (ROWS - 1);
    end

    // Scan FSM. It owns the board, the turn bit and the result pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ply_q    <= 1'b0;
            occupied <= '0;
            owner    <= '0;
            player   <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            done_row <= '0;
        end else if (clear) begin
            state    <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ply_q    <= 1'b0;
            occupied <= '0;
            owner    <= '0;
            player   <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            done_row <= '0;
        end else begin
            done    <= 1'b0;
            invalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop_valid) begin
                        col_q <= drop_col;
                        ply_q <= player;
                        row_q <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!col_ok) begin
                        // Out-of-range column: reject on the first scan cycle.
                        invalid <= 1'b1;
                        state   <= IDLE;
                    end else if (!cell_busy) begin
                        // First empty cell found: place the token and pass the turn.
                        occupied <= occupied | cell_mask;
                        if (ply_q) begin
                            owner <= owner | cell_mask;
                        end
                        done     <= 1'b1;
                        done_row <= row_q;
                        player   <= ~ply_q;
                        state    <= IDLE;
                    end else if (at_top) begin
                        // Column full: the same player must retry elsewhere.
                        invalid <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready only while idle; board_full is a plain reduction of the board.
    always_comb begin
        drop_ready = (state == IDLE);
        board_full = &occupied;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_gravity_drop_engine.sv
// tb_gravity_drop_engine
// Drives column requests into a 4x4 engine and a 3-column engine, and checks
// outcomes, latencies, board and turn state against a board-array model.

module tb_gravity_drop_engine;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main 4x4 DUT
    logic        clear = 1'b0;
    logic        drop_valid = 1'b0;
    logic [1:0]  drop_col = '0;
    logic        drop_ready;
    logic [15:0] occupied;
    logic [15:0] owner;
    logic        player;
    logic        done;
    logic [1:0]  done_row;
    logic        invalid;
    logic        board_full;
    logic [0:0]  state_dbg;

    gravity_drop_engine #(.COLS(4), .ROWS(4), .COL_W(2), .ROW_W(2)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
        .occupied(occupied), .owner(owner), .player(player),
        .done(done), .done_row(done_row), .invalid(invalid),
        .board_full(board_full), .state_dbg(state_dbg)
    );

    // Second DUT with 3 columns so an out-of-range column exists
    logic        clear3 = 1'b0;
    logic        drop_valid3 = 1'b0;
    logic [1:0]  drop_col3 = '0;
    logic        drop_ready3;
    logic [11:0] occupied3;
    logic [11:0] owner3;
    logic        player3;
    logic        done3;
    logic [1:0]  done_row3;
    logic        invalid3;
    logic        board_full3;
    logic [0:0]  state_dbg3;

    gravity_drop_engine #(.COLS(3), .ROWS(4), .COL_W(2), .ROW_W(2)) dut3 (
        .clk(clk), .reset(reset), .clear(clear3),
        .drop_valid(drop_valid3), .drop_col(drop_col3), .drop_ready(drop_ready3),
        .occupied(occupied3), .owner(owner3), .player(player3),
        .done(done3), .done_row(done_row3), .invalid(invalid3),
        .board_full(board_full3), .state_dbg(state_dbg3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: board[row][col] = -1 empty, 0 player1, 1 player2
    int mb[ROWS][COLS];
    bit m_player;

    logic [15:0] exp_q[$];

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = -1;
        m_player = 1'b0;
    endfunction

    // Gravity rule: a token lands in the lowest empty row of its column.
    function automatic void model_drop(input int col, output bit e_done,
                                       output int e_lat, output int e_row);
        e_done = 1'b0;
        e_lat  = ROWS;
        e_row  = -1;
        if (col >= COLS) begin
            e_lat = 1;
            return;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (mb[r][col] < 0) begin
                mb[r][col] = int'(m_player);
                m_player   = ~m_player;
                e_done     = 1'b1;
                e_lat      = r + 1;
                e_row      = r;
                return;
            end
        end
    endfunction

    function automatic logic [15:0] model_occ();
        logic [15:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mb[r][c] >= 0) v[r*COLS+c] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] model_own();
        logic [15:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mb[r][c] == 1) v[r*COLS+c] = 1'b1;
        return v;
    endfunction

    // Driver: one request on the main DUT, then wait (bounded) for its pulse.
    task automatic drive_drop(input int col, output bit g_done, output bit g_inv,
                              output int g_lat, output int g_row);
        logic [1:0] c2;
        c2 = 2'(col);
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = c2;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        g_done = 1'b0;
        g_inv  = 1'b0;
        g_lat  = 0;
        g_row  = -1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (done || invalid) begin
                g_done = done;
                g_inv  = invalid;
                g_lat  = i;
                g_row  = int'(done_row);
                break;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (drop_ready !== 1'b1 || occupied !== 16'h0 || owner !== 16'h0 ||
            player !== 1'b0 || done !== 1'b0 || invalid !== 1'b0 ||
            done_row !== 2'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b occ=%h own=%h ply=%b done=%b inv=%b row=%0d full=%b, need 1/0/0/0/0/0/0/0",
                     drop_ready, occupied, owner, player, done, invalid, done_row, board_full);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_first_drop();
        bit gd, gi, ed;
        int gl, gr, el, er;
        model_drop(1, ed, el, er);
        drive_drop(1, gd, gi, gl, gr);
        checks++;
        if (gd !== 1'b1 || gi !== 1'b0 || gl != 1 || gr != 0) begin
            errors++;
            $display("FAIL first_drop: done=%b inv=%b lat=%0d row=%0d, need 1/0/1/0", gd, gi, gl, gr);
        end
        checks++;
        if (occupied !== model_occ() || owner !== model_own() || player !== m_player) begin
            errors++;
            $display("FAIL first_drop_board: occ=%h own=%h ply=%b, need %h/%h/%b",
                     occupied, owner, player, model_occ(), model_own(), m_player);
        end
        // The pulse must drop after exactly one cycle
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || invalid !== 1'b0 || drop_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_drop_pulse: done=%b inv=%b ready=%b, need 0/0/1", done, invalid, drop_ready);
        end
    endtask

    task automatic test_stack_column();
        bit gd, gi, ed;
        int gl, gr, el, er;
        logic [15:0] occ_before;
        do_clear();
        for (int k = 0; k < 5; k++) begin
            occ_before = model_occ();
            model_drop(2, ed, el, er);
            drive_drop(2, gd, gi, gl, gr);
            checks++;
            if (gd !== ed || gi !== !ed || gl != el || (ed && gr != er)) begin
                errors++;
                $display("FAIL stack_col2[%0d]: done=%b inv=%b lat=%0d row=%0d, need %b/%b/%0d/%0d",
                         k, gd, gi, gl, gr, ed, !ed, el, er);
            end
            checks++;
            if (occupied !== model_occ() || owner !== model_own() || player !== m_player) begin
                errors++;
                $display("FAIL stack_col2_board[%0d]: occ=%h own=%h ply=%b, need %h/%h/%b",
                         k, occupied, owner, player, model_occ(), model_own(), m_player);
            end
            if (k == 4) begin
                checks++;
                if (occupied !== occ_before) begin
                    errors++;
                    $display("FAIL full_col_unchanged: occ=%h, need %h", occupied, occ_before);
                end
            end
        end
        checks++;
        if (owner[2] !== 1'b0 || owner[6] !== 1'b1 || owner[10] !== 1'b0 || owner[14] !== 1'b1) begin
            errors++;
            $display("FAIL stack_owner_pattern: own[2,6,10,14]=%b%b%b%b, need 0101",
                     owner[2], owner[6], owner[10], owner[14]);
        end
    endtask

    task automatic test_out_of_range();
        bit gd, gi;
        int gl;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drop_valid3 = 1'b1;
            drop_col3   = (k == 0) ? 2'd3 : 2'd2;
            @(posedge clk);
            #1;
            drop_valid3 = 1'b0;
            gd = 1'b0; gi = 1'b0; gl = 0;
            for (int i = 1; i <= 32; i++) begin
                @(posedge clk);
                #1;
                if (done3 || invalid3) begin
                    gd = done3; gi = invalid3; gl = i;
                    break;
                end
            end
            checks++;
            if (k == 0 && (gi !== 1'b1 || gd !== 1'b0 || gl != 1 ||
                           occupied3 !== 12'h000 || player3 !== 1'b0)) begin
                errors++;
                $display("FAIL out_of_range: inv=%b done=%b lat=%0d occ=%h ply=%b, need 1/0/1/000/0",
                         gi, gd, gl, occupied3, player3);
            end
            if (k == 1 && (gd !== 1'b1 || gi !== 1'b0 || gl != 1 || done_row3 !== 2'd0 ||
                           occupied3 !== 12'h004 || player3 !== 1'b1)) begin
                errors++;
                $display("FAIL cols3_last_col: done=%b inv=%b lat=%0d row=%0d occ=%h ply=%b, need 1/0/1/0/004/1",
                         gd, gi, gl, done_row3, occupied3, player3);
            end
        end
    endtask

    task automatic test_clear_mid_scan();
        bit gd, gi, ed;
        int gl, gr, el, er;
        do_clear();
        for (int k = 0; k < 3; k++) begin
            model_drop(0, ed, el, er);
            drive_drop(0, gd, gi, gl, gr);
        end
        checks++;
        if (occupied !== 16'h0111 || player !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: occ=%h ply=%b, need 0111/1", occupied, player);
        end
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 2'd0;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || invalid !== 1'b0 || drop_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_scan_busy[%0d]: done=%b inv=%b ready=%b, need 0/0/0",
                         i, done, invalid, drop_ready);
            end
        end
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (occupied !== 16'h0 || owner !== 16'h0 || player !== 1'b0 || drop_ready !== 1'b1 ||
            done !== 1'b0 || invalid !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort: occ=%h own=%h ply=%b ready=%b done=%b inv=%b, need 0/0/0/1/0/0",
                     occupied, owner, player, drop_ready, done, invalid);
        end
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || invalid !== 1'b0) begin
                errors++;
                $display("FAIL clear_no_pulse: done=%b inv=%b, need 0/0", done, invalid);
            end
        end
    endtask

    task automatic test_ignored_while_busy();
        bit gd, gi, ed;
        int gl, gr, el, er;
        do_clear();
        for (int k = 0; k < 2; k++) begin
            model_drop(0, ed, el, er);
            drive_drop(0, gd, gi, gl, gr);
        end
        model_drop(0, ed, el, er);
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 2'd0;
        @(posedge clk);
        #1;
        drop_col = 2'd3;
        gl = 0;
        gd = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (done || invalid) begin
                drop_valid = 1'b0;
                gd = done;
                gl = i;
                break;
            end
        end
        drop_valid = 1'b0;
        checks++;
        if (gd !== 1'b1 || gl != el || occupied !== model_occ() || player !== m_player) begin
            errors++;
            $display("FAIL busy_ignore: done=%b lat=%0d occ=%h ply=%b, need 1/%0d/%h/%b",
                     gd, gl, occupied, player, el, model_occ(), m_player);
        end
    endtask

    task automatic test_random_drops();
        bit gd, gi, ed;
        int gl, gr, el, er, col;
        logic [15:0] exp_v, got_v;
        do_clear();
        for (int k = 0; k < 40; k++) begin
            col = int'($urandom_range(0, 3));
            model_drop(col, ed, el, er);
            exp_q.push_back({ed, 8'(el), 7'(er)});
            drive_drop(col, gd, gi, gl, gr);
            got_v = {gd, 8'(gl), 7'(gd ? gr : -1)};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v || gi !== !gd) begin
                errors++;
                $display("FAIL random_drop[%0d] col %0d: done=%b inv=%b lat=%0d row=%0d, need done=%b lat=%0d row=%0d",
                         k, col, gd, gi, gl, gr, ed, el, er);
            end
            checks++;
            if (occupied !== model_occ() || owner !== model_own() || player !== m_player ||
                board_full !== (model_occ() == 16'hffff)) begin
                errors++;
                $display("FAIL random_board[%0d]: occ=%h own=%h ply=%b full=%b, need %h/%h/%b",
                         k, occupied, owner, player, board_full, model_occ(), model_own(), m_player);
            end
        end
    endtask

    task automatic test_fill_board();
        bit gd, gi, ed;
        int gl, gr, el, er;
        do_clear();
        for (int k = 0; k < 16; k++) begin
            model_drop(k % 4, ed, el, er);
            drive_drop(k % 4, gd, gi, gl, gr);
            if (k == 14) begin
                checks++;
                if (board_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_not_full_yet: full=%b, need 0", board_full);
                end
            end
        end
        checks++;
        if (board_full !== 1'b1 || occupied !== 16'hffff || owner !== model_own() || player !== m_player) begin
            errors++;
            $display("FAIL fill_board: full=%b occ=%h own=%h ply=%b, need 1/ffff/%h/%b",
                     board_full, occupied, owner, player, model_own(), m_player);
        end
        model_drop(1, ed, el, er);
        drive_drop(1, gd, gi, gl, gr);
        checks++;
        if (gi !== 1'b1 || gd !== 1'b0 || gl != ROWS || player !== m_player) begin
            errors++;
            $display("FAIL full_board_request: inv=%b done=%b lat=%0d ply=%b, need 1/0/%0d/%b",
                     gi, gd, gl, player, ROWS, m_player);
        end
    endtask

    task automatic test_async_reset();
        bit gd, gi, ed;
        int gl, gr, el, er;
        do_clear();
        for (int k = 0; k < 3; k++) begin
            model_drop(1, ed, el, er);
            drive_drop(1, gd, gi, gl, gr);
        end
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 2'd1;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (drop_ready !== 1'b1 || occupied !== 16'h0 || owner !== 16'h0 || player !== 1'b0 ||
            done !== 1'b0 || invalid !== 1'b0 || done_row !== 2'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b occ=%h own=%h ply=%b done=%b inv=%b row=%0d full=%b, need 1/0/0/0/0/0/0/0",
                     drop_ready, occupied, owner, player, done, invalid, done_row, board_full);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_drop();
        test_stack_column();
        test_out_of_range();
        test_clear_mid_scan();
        test_ignored_while_busy();
        test_random_drops();
        test_fill_board();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
